// File: rtl/tlp_xcvr_pkg.sv
// ============================================================================
//  Module   : tlp_xcvr_pkg
//  Purpose  : Shared types and constants for the TLP transceiver blocks.
//             Holds the F2C ring geometry, the F2C scheduler state encoding
//             and the request record handed to the TLP transmit engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tlp_xcvr_pkg;

    // F2C ring geometry (sizes in QWs)
    localparam int F2C_NUMCHUNKS = 4;     // ring depth in chunks, power of two
    localparam int F2C_CHUNKSIZE = 512;   // 4 KiB chunk
    localparam int F2C_TLPSIZE   = 16;    // 128 B data TLP payload

    // Chunk index into the ring; wraps naturally at NUM_CHUNKS
    typedef logic [$clog2(F2C_NUMCHUNKS)-1:0] F2CChunkIndex;

    // F2C scheduler states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        MTR  = 2'd2
    } SchedState;

    // One request towards the TLP transmit engine
    typedef struct packed {
        logic        isMtr;     // 0 = data TLP, 1 = metrics write
        logic [31:0] addr;      // target QW address
        logic [15:0] lenQW;     // payload length in QWs
        logic [63:0] mtrData;   // metrics QW, meaningful when isMtr = 1
    } TxReq;

endpackage

`default_nettype wire

// File: rtl/f2c_dma_sched.sv
// ============================================================================
//  Module   : f2c_dma_sched
//  Purpose  : Producer-side scheduler for the FPGA->CPU DMA ring. Splits each
//             chunk into posted-write data TLP requests targeting the host
//             ring, never overruns the host read pointer, and issues a one-QW
//             metrics write after every chunk and on C2F read-pointer changes.
//  Ports    :
//    clk_in, reset_in        clock, synchronous active-high reset
//    dmaEnable_in            level, allows new chunks to start
//    ptrReset_in             pulse, synchronous clear of all ring state
//    f2cBase_in, mtrBase_in  QW addresses of the F2C ring / metrics QW
//    f2cRdPtr_in             host read pointer (chunk index)
//    c2fRdPtr_in/_Upd_in     C2F read pointer and its change strobe
//    srcTlpAvail_in          source holds at least one TLP worth of data
//    req*_out, reqReady_in   valid/ready request channel to the TLP engine
//    f2cWrPtr_out, busy_out  current write pointer, not-idle status
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module f2c_dma_sched
    import tlp_xcvr_pkg::*;
#(
    parameter int NUM_CHUNKS = F2C_NUMCHUNKS,
    parameter int CHUNK_QWS  = F2C_CHUNKSIZE,
    parameter int TLP_QWS    = F2C_TLPSIZE,
    parameter int C2F_IDX_W  = 2
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic                          dmaEnable_in,
    input  logic                          ptrReset_in,
    input  logic [31:0]                   f2cBase_in,
    input  logic [31:0]                   mtrBase_in,
    input  logic [$clog2(NUM_CHUNKS)-1:0] f2cRdPtr_in,
    input  logic [C2F_IDX_W-1:0]          c2fRdPtr_in,
    input  logic                          c2fRdPtrUpd_in,
    input  logic                          srcTlpAvail_in,
    output logic                          reqValid_out,
    input  logic                          reqReady_in,
    output logic                          reqIsMtr_out,
    output logic [31:0]                   reqAddr_out,
    output logic [15:0]                   reqLenQW_out,
    output logic [63:0]                   reqMtrData_out,
    output logic [$clog2(NUM_CHUNKS)-1:0] f2cWrPtr_out,
    output logic                          busy_out
);

    localparam int IDX_W          = $clog2(NUM_CHUNKS);
    localparam int TLPS_PER_CHUNK = CHUNK_QWS / TLP_QWS;
    localparam int TIDX_W         = (TLPS_PER_CHUNK > 1) ? $clog2(TLPS_PER_CHUNK) : 1;
    localparam logic [TIDX_W-1:0] LAST_TLP = TIDX_W'(TLPS_PER_CHUNK - 1);

    SchedState            state_q,  state_d;
    logic [TIDX_W-1:0]    tlpIdx_q, tlpIdx_d;
    logic [IDX_W-1:0]     wrPtr_q,  wrPtr_d;
    logic                 mtrDirty_q, mtrDirty_d;
    logic                 valid_q,  valid_d;
    TxReq                 req_q,    req_d;

    logic [IDX_W-1:0]     w_wrPtrInc;
    logic [TIDX_W-1:0]    w_tlpIdxInc;
    logic                 w_full;
    logic                 w_hs;

    assign w_wrPtrInc  = wrPtr_q + IDX_W'(1);
    assign w_tlpIdxInc = tlpIdx_q + TIDX_W'(1);
    // One slot is always left empty so that full and empty are distinguishable
    assign w_full      = (w_wrPtrInc == f2cRdPtr_in);
    assign w_hs        = valid_q & reqReady_in;

    // Data TLP request for TLP 'idx' of chunk 'ptr' (address wraps mod 2^32)
    function automatic TxReq mk_data(input logic [IDX_W-1:0] ptr,
                                     input logic [TIDX_W-1:0] idx,
                                     input logic [31:0] base);
        TxReq r;
        r.isMtr   = 1'b0;
        r.addr    = base + 32'(ptr) * 32'(CHUNK_QWS) + 32'(idx) * 32'(TLP_QWS);
        r.lenQW   = 16'(TLP_QWS);
        r.mtrData = '0;
        return r;
    endfunction

    // Metrics write; the payload is snapshotted here, on entry to MTR
    function automatic TxReq mk_mtr(input logic [IDX_W-1:0] ptr,
                                    input logic [C2F_IDX_W-1:0] c2f,
                                    input logic [31:0] base);
        TxReq r;
        r.isMtr   = 1'b1;
        r.addr    = base;
        r.lenQW   = 16'd1;
        r.mtrData = {32'(c2f), 32'(ptr)};
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        tlpIdx_d   = tlpIdx_q;
        wrPtr_d    = wrPtr_q;
        mtrDirty_d = mtrDirty_q | c2fRdPtrUpd_in;
        valid_d    = valid_q;
        req_d      = req_q;

        case (state_q)
            IDLE: begin
                // Pending metrics win over starting a new chunk
                if (mtrDirty_q) begin
                    state_d    = MTR;
                    valid_d    = 1'b1;
                    req_d      = mk_mtr(wrPtr_q, c2fRdPtr_in, mtrBase_in);
                    // The snapshot covers everything seen so far; only a
                    // strobe arriving this very cycle keeps the flag set.
                    mtrDirty_d = c2fRdPtrUpd_in;
                end else if (dmaEnable_in && !w_full) begin
                    state_d  = DATA;
                    tlpIdx_d = '0;
                    if (srcTlpAvail_in) begin
                        valid_d = 1'b1;
                        req_d   = mk_data(wrPtr_q, '0, f2cBase_in);
                    end
                end
            end

            DATA: begin
                if (w_hs) begin
                    if (tlpIdx_q == LAST_TLP) begin
                        wrPtr_d    = w_wrPtrInc;
                        tlpIdx_d   = '0;
                        state_d    = MTR;
                        valid_d    = 1'b1;
                        req_d      = mk_mtr(w_wrPtrInc, c2fRdPtr_in, mtrBase_in);
                        mtrDirty_d = c2fRdPtrUpd_in;
                    end else begin
                        // Reload on the handshake cycle for back-to-back TLPs
                        tlpIdx_d = w_tlpIdxInc;
                        valid_d  = srcTlpAvail_in;
                        if (srcTlpAvail_in) begin
                            req_d = mk_data(wrPtr_q, w_tlpIdxInc, f2cBase_in);
                        end
                    end
                end else if (!valid_q && srcTlpAvail_in) begin
                    valid_d = 1'b1;
                    req_d   = mk_data(wrPtr_q, tlpIdx_q, f2cBase_in);
                end
            end

            MTR: begin
                if (w_hs) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in || ptrReset_in) begin
            state_q    <= IDLE;
            tlpIdx_q   <= '0;
            wrPtr_q    <= '0;
            mtrDirty_q <= 1'b0;
            valid_q    <= 1'b0;
            req_q      <= '0;
        end else begin
            state_q    <= state_d;
            tlpIdx_q   <= tlpIdx_d;
            wrPtr_q    <= wrPtr_d;
            mtrDirty_q <= mtrDirty_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
        end
    end

    assign reqValid_out   = valid_q;
    assign reqIsMtr_out   = req_q.isMtr;
    assign reqAddr_out    = req_q.addr;
    assign reqLenQW_out   = req_q.lenQW;
    assign reqMtrData_out = req_q.mtrData;
    assign f2cWrPtr_out   = wrPtr_q;
    assign busy_out       = (state_q != IDLE);

endmodule

`default_nettype wire
